fpu_pipe_ctrl: RTL and testbench
================================

# fpu_pipe_ctrl

Issue/writeback controller for the fixed-latency, non-stallable FP adder pipeline (`fadd`, 2 internal register stages). It accepts tagged operand pairs from the core over a valid/ready handshake and drives them into the pipeline. It tracks each in-flight operation in a valid/tag shift register and captures every pipeline result into a result FIFO, which is drained to the register-file writeback port over a second valid/ready handshake. Admission is credit-based, so a result arriving from the pipeline always has a FIFO slot, even under writeback backpressure.

## Interface
- `LAT`, 2: pipeline latency in clock edges from operand presentation to a valid result (`fadd` = 2).
- `TAGW`, 5: width of the destination-register tag.
- `DEPTH`, 4: result FIFO entries and total credit count; must be ≥ 1; ≥ `LAT`+2 for full throughput.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: core offers an operation.
- `req_ready` out 1: controller can accept.
- `req_tag` in `TAGW`: destination tag.
- `req_x1`, `req_x2` in 32: IEEE-754 single operands.
- `pipe_x1`, `pipe_x2` out 32: operands to the pipeline; combinational copies of `req_x1`/`req_x2`.
- `pipe_y` in 32: pipeline result.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback accepts.
- `wb_tag` out `TAGW`, `wb_data` out 32: head-of-FIFO tag/result.
- `busy` out 1: any accepted operation not yet written back.

## Operation
- Accept = `req_valid & req_ready`. Pop = `wb_valid & wb_ready`.
- Credit counter `cnt`, width clog2(`DEPTH`+1): number of accepted operations not yet popped. `cnt` += accept, −= pop; both in one cycle leaves it unchanged.
- `req_ready` = (`cnt` < `DEPTH`). It is registered-state only, with no combinational path from `wb_ready` or `req_valid`.
- Shift register `vld[0..LAT-1]`, `tag[0..LAT-1]`:
  - On every edge, stage 0 loads {accept, `req_tag`} and stage i loads stage i−1.
  - Non-accept cycles shift a bubble (valid 0).
- When `vld[LAT-1]` = 1, push {`tag[LAT-1]`, `pipe_y`} into the FIFO on that edge. `pipe_y` is ignored when `vld[LAT-1]` = 0.
- FIFO: circular, `DEPTH` entries, read/write pointers wrap modulo `DEPTH`, with an occupancy counter.
  - Simultaneous push and pop is legal at any occupancy, including full (pop frees the head while push writes the tail).
  - Push never occurs while the FIFO is full with no pop; the credit scheme guarantees this. The bench asserts it.
- `wb_valid` = FIFO non-empty. `wb_tag`/`wb_data` = head entry. They hold stable while `wb_valid` & !`wb_ready`.
- Results leave in strict acceptance order. No bypass: a result always passes through the FIFO.
- `busy` = (`cnt` ≠ 0).
- Reset (at any time, including with operations in flight):
  - Clears `vld`, `cnt`, pointers and occupancy; in-flight results are discarded.
  - Outputs during and after reset: `req_ready`=1 (`DEPTH` ≥ 1), `wb_valid`=0, `busy`=0, `wb_tag`=0, `wb_data`=0.
  - FIFO storage and `tag[]` need no reset.

## Timing
- Operation accepted in cycle k → `pipe_y` valid in cycle k+`LAT` → captured at end of k+`LAT` → `wb_valid` in cycle k+`LAT`+1 (3 cycles for default).
- Throughput: 1 op/cycle sustained when `wb_ready`=1 and `DEPTH` ≥ `LAT`+2. Default steady-state `cnt` = 3 < 4.
- `wb_ready` held low: exactly `DEPTH` operations are accepted, then `req_ready`=0 starting the cycle after the `DEPTH`th accept.
- First `req_ready` rise after a pop is the cycle after the pop edge.

## Test plan
- **Single op:** after reset, accept x1=0x3F800000, x2=0x40000000, tag=3 in cycle k with `wb_ready`=1 → `wb_valid`=1, `wb_tag`=3, `wb_data`=0x40400000 exactly in cycle k+3. `busy` is 1 in cycles k+1..k+3 and 0 in k+4.
- **Back-to-back:** 8 consecutive accepts, tags 0..7, x1=i·1.0, x2=1.0, `wb_ready`=1 → `req_ready` never drops, `wb_valid` high cycles k+3..k+10, tags 0..7 in order, each `wb_data` = (i+1)·1.0.
- **Backpressure:** `wb_ready`=0, `req_valid`=1 continuously → 4 accepts, then `req_ready`=0 and `wb_valid`=1 with the head stable (tag 0). Raising `wb_ready` drains tags 0..3 in order, and `req_ready` returns the cycle after the first pop.
- **Simultaneous accept and pop at `cnt`=`DEPTH`−1:** `cnt` stays 3, `req_ready` stays 1, no FIFO overflow assertion fires, and ordering is preserved.
- **Reset mid-flight:** assert `rst` asynchronously with 2 ops in the pipeline and 2 in the FIFO → `wb_valid`=0, `busy`=0, `req_ready`=1 immediately (before the next edge). After release, no stale result ever appears on `wb`, even with non-zero `pipe_y`.
- **Bubbles:** alternate `req_valid` 1/0 with random `wb_ready` → the result stream equals the reference model in order and count.

Source files
------------

// File: rtl/fpu_pipe_ctrl.sv
// Issue/writeback controller for the fixed-latency FP adder pipeline.
// Credits bound in-flight ops so every pipeline result is guaranteed a result FIFO slot.
module fpu_pipe_ctrl #(
   parameter int LAT   = 2,
   parameter int TAGW  = 5,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [TAGW-1:0] req_tag,
   input  logic [31:0]     req_x1,
   input  logic [31:0]     req_x2,
   output logic [31:0]     pipe_x1,
   output logic [31:0]     pipe_x2,
   input  logic [31:0]     pipe_y,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [TAGW-1:0] wb_tag,
   output logic [31:0]     wb_data,
   output logic            busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Both ports: a transfer happens on an edge where valid & ready are high;
   // the source holds its payload stable until the transfer, ready never depends on valid.
   logic            accept;
   logic            pop;
   logic            push;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LAT-1:0]  vld_q, vld_d;
   logic [TAGW-1:0] tag_q [LAT];
   logic [TAGW-1:0] tag_d [LAT];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   occ_q, occ_d;
   logic [TAGW-1:0] mem_tag_q  [DEPTH];
   logic [31:0]     mem_data_q [DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pipe_x1   = req_x1;
   assign pipe_x2   = req_x2;
   assign req_ready = (cnt_q < CW'(DEPTH));
   assign busy      = (cnt_q != '0);
   assign wb_valid  = (occ_q != '0);
   // Head is forced to zero when empty so unreset storage never reaches the port.
   assign wb_tag    = wb_valid ? mem_tag_q[rd_ptr_q]  : '0;
   assign wb_data   = wb_valid ? mem_data_q[rd_ptr_q] : '0;

   assign accept = req_valid & req_ready;
   assign pop    = wb_valid & wb_ready;
   assign push   = vld_q[LAT-1];

   always_comb begin
      cnt_d = cnt_q;
      if (accept && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!accept && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_comb begin
      vld_d    = '0;
      vld_d[0] = accept;
      tag_d[0] = req_tag;
      for (int i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         tag_d[i] = tag_q[i-1];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
         occ_d = occ_q + CW'(1);
      end else if (!push && pop) begin
         occ_d = occ_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Tags and FIFO payload are qualified by vld_q/occ_q, so they carry no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LAT; i++) begin
         tag_q[i] <= tag_d[i];
      end
      if (push) begin
         mem_tag_q[wr_ptr_q]  <= tag_q[LAT-1];
         mem_data_q[wr_ptr_q] <= pipe_y;
      end
   end

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Bench for fpu_pipe_ctrl: behavioural fadd pipeline, per-cycle reference monitor
// and scenario tasks with cycle-exact checks.
module tb_fpu_pipe_ctrl;

   localparam int LAT   = 2;
   localparam int TAGW  = 5;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [TAGW-1:0] req_tag = '0;
   logic [31:0]     req_x1 = '0;
   logic [31:0]     req_x2 = '0;
   logic [31:0]     pipe_x1;
   logic [31:0]     pipe_x2;
   logic [31:0]     pipe_y;
   logic            wb_valid;
   logic            wb_ready = 1'b0;
   logic [TAGW-1:0] wb_tag;
   logic [31:0]     wb_data;
   logic            busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int cur_a = 0;
   int cur_b = 0;

   fpu_pipe_ctrl #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
      .req_x1(req_x1), .req_x2(req_x2),
      .pipe_x1(pipe_x1), .pipe_x2(pipe_x2), .pipe_y(pipe_y),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Non-negative integer-valued floats only (< 2^24).
   function automatic logic [31:0] int_to_fp(input int n);
      logic [31:0] r;
      int p;
      r = '0;
      if (n > 0) begin
         p = 0;
         for (int i = 0; i < 24; i++) if (n[i]) p = i;
         r[30:23] = 8'(p + 127);
         r[22:0]  = 23'((n << (23 - p)) & 32'h007F_FFFF);
      end
      return r;
   endfunction

   function automatic int fp_to_int(input logic [31:0] f);
      int e;
      int m;
      if (f[30:23] == 8'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = int'({8'd0, 1'b1, f[22:0]});
      return m >>> (23 - e);
   endfunction

   // Two-register fadd stand-in; starts with garbage so stale pipe_y is non-zero.
   logic [31:0] pipe_s1 = 32'hDEAD_BEEF;
   logic [31:0] pipe_s2 = 32'hCAFE_F00D;
   always @(posedge clk) begin
      pipe_s1 <= int_to_fp(fp_to_int(pipe_x1) + fp_to_int(pipe_x2));
      pipe_s2 <= pipe_s1;
   end
   assign pipe_y = pipe_s2;

   // Reference monitor: sampled on the falling edge, describes the coming rising edge.
   logic [TAGW+31:0] exp_q[$];
   int               arrive_q[$];
   int               cyc = 0;
   int               cnt_m = 0;
   int               occ_m = 0;
   logic             hold_v = 1'b0;
   logic [TAGW+31:0] hold_val = '0;

   always @(negedge clk) begin
      logic acc, pop_m, push_m;
      logic [TAGW+31:0] exp_e;
      cyc++;
      if (rst) begin
         exp_q.delete();
         arrive_q.delete();
         cnt_m  = 0;
         occ_m  = 0;
         hold_v = 1'b0;
      end else begin
         acc    = req_valid & req_ready;
         pop_m  = wb_valid & wb_ready;
         push_m = (arrive_q.size() > 0) && (arrive_q[0] == cyc - LAT);
         tests_run++;
         if (req_ready !== (cnt_m < DEPTH)) begin
            tests_failed++;
            $display("FAIL mon_req_ready cyc %0d: got %b expected %b", cyc, req_ready, cnt_m < DEPTH);
         end
         tests_run++;
         if (busy !== (cnt_m != 0)) begin
            tests_failed++;
            $display("FAIL mon_busy cyc %0d: got %b expected %b", cyc, busy, cnt_m != 0);
         end
         tests_run++;
         if (wb_valid !== (occ_m != 0)) begin
            tests_failed++;
            $display("FAIL mon_wb_valid cyc %0d: got %b expected %b", cyc, wb_valid, occ_m != 0);
         end
         if (hold_v && wb_valid) begin
            tests_run++;
            if ({wb_tag, wb_data} !== hold_val) begin
               tests_failed++;
               $display("FAIL mon_hold cyc %0d: got %h expected %h", cyc, {wb_tag, wb_data}, hold_val);
            end
         end
         if (pop_m) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL mon_spurious_pop cyc %0d: got %h expected no result", cyc, {wb_tag, wb_data});
            end else begin
               exp_e = exp_q.pop_front();
               if ({wb_tag, wb_data} !== exp_e) begin
                  tests_failed++;
                  $display("FAIL mon_result cyc %0d: got %h expected %h", cyc, {wb_tag, wb_data}, exp_e);
               end
            end
         end
         if (push_m) begin
            tests_run++;
            if (occ_m == DEPTH && !pop_m) begin
               tests_failed++;
               $display("FAIL mon_fifo_overflow cyc %0d: got occupancy %0d expected below %0d", cyc, occ_m, DEPTH);
            end
            void'(arrive_q.pop_front());
         end
         hold_v   = wb_valid & ~wb_ready;
         hold_val = {wb_tag, wb_data};
         occ_m    = occ_m + int'(push_m) - int'(pop_m);
         cnt_m    = cnt_m + int'(acc) - int'(pop_m);
         if (acc) begin
            exp_q.push_back({req_tag, int_to_fp(cur_a + cur_b)});
            arrive_q.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [TAGW-1:0] t, input int a, input int b);
      req_valid = v;
      req_tag   = t;
      cur_a     = a;
      cur_b     = b;
      req_x1    = int_to_fp(a);
      req_x2    = int_to_fp(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, '0, 0, 0);
      wb_ready = 1'b1;
      repeat (3) step();
      tests_run++;
      if ({req_ready, wb_valid, busy} !== 3'b100 || wb_tag !== '0 || wb_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got rdy/vld/busy %b tag %h data %h expected 100 00 00000000",
                  {req_ready, wb_valid, busy}, wb_tag, wb_data);
      end
      rst = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_single_op();
      wb_ready = 1'b1;
      drive(1'b1, 5'd3, 1, 2);
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_ready: got %b expected 1", req_ready);
      end
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) drive(1'b0, '0, 0, 0);
         tests_run++;
         if (wb_valid !== (c == 3) || busy !== (c <= 3)) begin
            tests_failed++;
            $display("FAIL single_timing k+%0d: got vld %b busy %b expected vld %b busy %b",
                     c, wb_valid, busy, c == 3, c <= 3);
         end
         if (c == 3) begin
            tests_run++;
            if (wb_tag !== 5'd3 || wb_data !== 32'h4040_0000) begin
               tests_failed++;
               $display("FAIL single_result: got tag %0d data %h expected tag 3 data 40400000", wb_tag, wb_data);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c < 8) drive(1'b1, 5'(c), c, 1);
         else drive(1'b0, '0, 0, 0);
         if (c < 8) begin
            tests_run++;
            if (req_ready !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_ready k+%0d: got %b expected 1", c, req_ready);
            end
         end
         tests_run++;
         if (wb_valid !== (c >= 3 && c <= 10)) begin
            tests_failed++;
            $display("FAIL b2b_valid k+%0d: got %b expected %b", c, wb_valid, c >= 3 && c <= 10);
         end else if (wb_valid) begin
            tests_run++;
            if (wb_tag !== 5'(c - 3) || wb_data !== int_to_fp(c - 2)) begin
               tests_failed++;
               $display("FAIL b2b_result k+%0d: got tag %0d data %h expected tag %0d data %h",
                        c, wb_tag, wb_data, c - 3, int_to_fp(c - 2));
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d [4];
      int a, b;
      wb_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         a = $urandom_range(0, 1000);
         b = $urandom_range(0, 1000);
         drive(1'b1, 5'(c), a, b);
         if (c < 4) exp_d[c] = int_to_fp(a + b);
         tests_run++;
         if (req_ready !== (c < 4)) begin
            tests_failed++;
            $display("FAIL bp_ready c%0d: got %b expected %b", c, req_ready, c < 4);
         end
         if (c >= 6) begin
            tests_run++;
            if (wb_valid !== 1'b1 || wb_tag !== 5'd0 || wb_data !== exp_d[0]) begin
               tests_failed++;
               $display("FAIL bp_head c%0d: got vld %b tag %0d data %h expected 1 0 %h",
                        c, wb_valid, wb_tag, wb_data, exp_d[0]);
            end
         end
         step();
      end
      drive(1'b0, '0, 0, 0);
      wb_ready = 1'b1;
      for (int d = 0; d < 5; d++) begin
         tests_run++;
         if (req_ready !== (d >= 1)) begin
            tests_failed++;
            $display("FAIL bp_ready_return d%0d: got %b expected %b", d, req_ready, d >= 1);
         end
         tests_run++;
         if (d < 4) begin
            if (wb_valid !== 1'b1 || wb_tag !== 5'(d) || wb_data !== exp_d[d]) begin
               tests_failed++;
               $display("FAIL bp_drain d%0d: got vld %b tag %0d data %h expected 1 %0d %h",
                        d, wb_valid, wb_tag, wb_data, d, exp_d[d]);
            end
         end else if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain_empty: got %b expected 0", wb_valid);
         end
         step();
      end
   endtask

   task automatic test_accept_pop_at_limit();
      wb_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 5'(c + 10), $urandom_range(0, 1000), $urandom_range(0, 1000));
         step();
      end
      drive(1'b0, '0, 0, 0);
      repeat (3) step();
      wb_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         drive(1'b1, 5'($urandom_range(0, 31)), $urandom_range(0, 1000), $urandom_range(0, 1000));
         tests_run++;
         if (req_ready !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL limit_ready c%0d: got rdy %b busy %b expected 1 1", c, req_ready, busy);
         end
         step();
      end
      drive(1'b0, '0, 0, 0);
      repeat (8) step();
      tests_run++;
      if (wb_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL limit_drained: got vld %b busy %b pending %0d expected 0 0 0",
                  wb_valid, busy, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_flight();
      wb_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 5'(c + 20), c + 4, 7);
         step();
      end
      drive(1'b0, '0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({req_ready, wb_valid, busy} !== 3'b100 || wb_tag !== '0 || wb_data !== '0) begin
         tests_failed++;
         $display("FAIL midrst_async: got rdy/vld/busy %b tag %h data %h expected 100 00 00000000",
                  {req_ready, wb_valid, busy}, wb_tag, wb_data);
      end
      step();
      step();
      rst = 1'b0;
      wb_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tests_run++;
         if (wb_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_stale c%0d: got vld %b busy %b expected 0 0", c, wb_valid, busy);
         end
         step();
      end
      drive(1'b1, 5'd9, 5, 6);
      step();
      drive(1'b0, '0, 0, 0);
      step();
      step();
      tests_run++;
      if (wb_valid !== 1'b1 || wb_tag !== 5'd9 || wb_data !== int_to_fp(11)) begin
         tests_failed++;
         $display("FAIL midrst_after: got vld %b tag %0d data %h expected 1 9 %h",
                  wb_valid, wb_tag, wb_data, int_to_fp(11));
      end
      step();
   endtask

   task automatic test_bubbles();
      for (int c = 0; c < 80; c++) begin
         wb_ready = 1'($urandom_range(0, 1));
         if (c % 2 == 0) drive(1'b1, 5'($urandom_range(0, 31)), $urandom_range(0, 1000), $urandom_range(0, 1000));
         else drive(1'b0, '0, 0, 0);
         step();
      end
      drive(1'b0, '0, 0, 0);
      wb_ready = 1'b1;
      repeat (10) step();
      tests_run++;
      if (exp_q.size() != 0 || wb_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bubbles_count: got pending %0d vld %b busy %b expected 0 0 0",
                  exp_q.size(), wb_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_back_to_back();
      test_backpressure();
      test_accept_pop_at_limit();
      test_reset_mid_flight();
      test_bubbles();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
